alu_frame_ctrl: RTL and testbench

ALU_FRAME_CTRL -- requirements
Module: alu_frame_ctrl

---
 rtl/alu_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_frame_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_ctrl.sv
// alu_frame_ctrl
// Receives SOF/OP/A/B/CHK frames from a UART receiver, drives a combinational
// ALU with the decoded operands, and answers with the result byte followed by
// a status byte, or with a single NAK byte when the frame is rejected.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | hunting for SOF, everything else dropped
// GET_OP    | waiting for the opcode byte
// GET_A     | waiting for operand A
// GET_B     | waiting for operand B
// GET_CHK   | waiting for checksum, then verdict (EXEC or SEND_NAK)
// EXEC      | two cycles: drive ALU operands, then latch result/flags
// SEND_RES  | one-cycle start pulse carrying the ALU result
// WAIT_RES  | transmitter busy with result byte
// SEND_STAT | one-cycle start pulse carrying {0.., overflow, zero}
// WAIT_STAT | transmitter busy with status byte
// SEND_NAK  | one-cycle start pulse carrying NAK
// WAIT_NAK  | transmitter busy with NAK byte
module alu_frame_ctrl #(
    parameter int                 NB_DATA       = 8,
    parameter int                 NB_ALU_OP     = 6,
    parameter logic [NB_DATA-1:0] SOF           = 8'hAA,
    parameter logic [NB_DATA-1:0] NAK           = 8'h15,
    parameter int                 NB_TIMEOUT    = 16,
    parameter int                 TIMEOUT_TICKS = 3200
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_res,
    input  logic                 i_alu_overflow,
    input  logic                 i_alu_zero,
    output logic                 o_tx_start,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic [NB_ALU_OP-1:0] o_alu_OP,
    output logic [NB_DATA-1:0]   o_alu_A,
    output logic [NB_DATA-1:0]   o_alu_B,
    output logic                 o_busy,
    output logic [7:0]           o_err_count
);

    typedef enum logic [3:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_STAT,
        WAIT_STAT,
        SEND_NAK,
        WAIT_NAK
    } state_t;

    // Expiry fires on the tick that would bring the count to TIMEOUT_TICKS.
    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);

    state_t                state;
    state_t                next_state;
    logic [NB_DATA-1:0]    op_q;
    logic [NB_DATA-1:0]    a_q;
    logic [NB_DATA-1:0]    b_q;
    logic [NB_DATA-1:0]    res_q;
    logic                  ovf_q;
    logic                  zero_q;
    logic                  exec_second;
    logic [NB_TIMEOUT-1:0] tmo_cnt;
    logic                  in_get;
    logic                  tmo_hit;
    logic                  chk_ok;
    logic                  op_ok;
    logic [NB_DATA-1:0]    stat_byte;

    assign in_get    = (state == GET_OP) || (state == GET_A) ||
                       (state == GET_B)  || (state == GET_CHK);
    // A byte arriving on the expiry tick wins over the timeout.
    assign tmo_hit   = in_get && !i_rx_done && i_tick && (tmo_cnt == TMO_LAST);
    assign chk_ok    = (i_rx_data == (op_q ^ a_q ^ b_q));
    assign op_ok     = (op_q[NB_DATA-1:NB_ALU_OP] == '0);
    assign stat_byte = {{(NB_DATA-2){1'b0}}, ovf_q, zero_q};
    assign o_busy    = (state != IDLE);
    assign o_tx_start = (state == SEND_RES) || (state == SEND_STAT) || (state == SEND_NAK);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state decode; a timeout overrides whatever the GET_* state wanted.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (i_rx_done && (i_rx_data == SOF)) next_state = GET_OP;
            GET_OP:    if (i_rx_done) next_state = GET_A;
            GET_A:     if (i_rx_done) next_state = GET_B;
            GET_B:     if (i_rx_done) next_state = GET_CHK;
            GET_CHK:   if (i_rx_done) next_state = (chk_ok && op_ok) ? EXEC : SEND_NAK;
            EXEC:      if (exec_second) next_state = SEND_RES;
            SEND_RES:  next_state = WAIT_RES;
            WAIT_RES:  if (i_tx_done) next_state = SEND_STAT;
            SEND_STAT: next_state = WAIT_STAT;
            WAIT_STAT: if (i_tx_done) next_state = IDLE;
            SEND_NAK:  next_state = WAIT_NAK;
            WAIT_NAK:  if (i_tx_done) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (tmo_hit) next_state = IDLE;
    end

    // Capture frame bytes; SOF-valued bytes here are plain data.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (i_rx_done) begin
            case (state)
                GET_OP:  op_q <= i_rx_data;
                GET_A:   a_q  <= i_rx_data;
                GET_B:   b_q  <= i_rx_data;
                default: ;
            endcase
        end
    end

    // EXEC sequencing: first cycle loads the ALU operands, second latches its outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            exec_second <= 1'b0;
            o_alu_OP    <= '0;
            o_alu_A     <= '0;
            o_alu_B     <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            exec_second <= (state == EXEC) && !exec_second;
            if ((state == EXEC) && !exec_second) begin
                o_alu_OP <= op_q[NB_ALU_OP-1:0];
                o_alu_A  <= a_q;
                o_alu_B  <= b_q;
            end
            if ((state == EXEC) && exec_second) begin
                res_q  <= i_alu_res;
                ovf_q  <= i_alu_overflow;
                zero_q <= i_alu_zero;
            end
        end
    end

    // Transmit byte is loaded on entry to each SEND_* state and held through WAIT_*.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_tx_data <= '0;
        end else begin
            case (next_state)
                SEND_RES:  o_tx_data <= i_alu_res;
                SEND_STAT: o_tx_data <= stat_byte;
                SEND_NAK:  o_tx_data <= NAK;
                default:   ;
            endcase
        end
    end

    // Inter-byte timeout: counts ticks while collecting a frame only.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            tmo_cnt <= '0;
        end else if (!in_get || i_rx_done || tmo_hit) begin
            tmo_cnt <= '0;
        end else if (i_tick) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Saturating error counter: timeouts and rejected frames.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_err_count <= '0;
        end else if ((tmo_hit || (next_state == SEND_NAK && state == GET_CHK)) &&
                     (o_err_count != 8'hFF)) begin
            o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Testbench for alu_frame_ctrl: scoreboard of expected TX bytes, a small
// combinational ALU model and an auto-responding transmitter.
module tb_alu_frame_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_res;
    logic       i_alu_overflow;
    logic       i_alu_zero;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic [5:0] o_alu_OP;
    logic [7:0] o_alu_A;
    logic [7:0] o_alu_B;
    logic       o_busy;
    logic [7:0] o_err_count;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_err;
    int tx_lat = 3;

    alu_frame_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .i_tx_done     (i_tx_done),
        .i_alu_res     (i_alu_res),
        .i_alu_overflow(i_alu_overflow),
        .i_alu_zero    (i_alu_zero),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_alu_OP      (o_alu_OP),
        .o_alu_A       (o_alu_A),
        .o_alu_B       (o_alu_B),
        .o_busy        (o_busy),
        .o_err_count   (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    // ALU model: {overflow, zero, result}
    function automatic logic [9:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       v;
        r = 8'h00;
        v = 1'b0;
        case (op)
            6'h20: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
            6'h22: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            default: r = 8'h00;
        endcase
        return {v, (r == 8'h00), r};
    endfunction

    always_comb {i_alu_overflow, i_alu_zero, i_alu_res} = alu_fn(o_alu_OP, o_alu_A, o_alu_B);

    // Transmitter model: tx_done tx_lat cycles after each start pulse.
    initial begin
        i_tx_done = 1'b0;
        @(negedge i_clk);
        forever begin
            if (o_tx_start === 1'b1) begin
                repeat (tx_lat) @(negedge i_clk);
                i_tx_done = 1'b1;
                @(negedge i_clk);
                i_tx_done = 1'b0;
            end else begin
                @(negedge i_clk);
            end
        end
    end

    // Scoreboard monitor: compares every start pulse to the queue head and
    // watches that the byte stays put until tx_done.
    logic       pending = 1'b0;
    logic       stable_bad = 1'b0;
    logic [7:0] held = 8'h00;
    always @(posedge i_clk) begin
        #2;
        if (i_reset === 1'b0) begin
            pending = 1'b0;
        end else begin
            if (pending && i_tx_done === 1'b1) begin
                checks++;
                if (stable_bad) begin
                    errors++;
                    $display("FAIL tx_stable: tx_data changed before tx_done, held=%02h", held);
                end
                pending = 1'b0;
            end else if (pending && o_tx_data !== held) begin
                stable_bad = 1'b1;
            end
            if (o_tx_start === 1'b1) begin
                checks++;
                if (pending) begin
                    errors++;
                    $display("FAIL tx_double_start: start while previous byte %02h pending", held);
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %02h, expected no transmission", o_tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, expected %02h", o_tx_data, e);
                    end
                end
                pending    = 1'b1;
                held       = o_tx_data;
                stable_bad = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(8'hAA);
        send_byte(op);
        send_byte(a);
        send_byte(b);
        send_byte(op ^ a ^ b);
    endtask

    task automatic push_resp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [9:0] r;
        r = alu_fn(op[5:0], a, b);
        exp_q.push_back(r[7:0]);
        exp_q.push_back({6'b0, r[9:8]});
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (o_tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b, expected 0", o_tx_start); end
        checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %02h, expected 00", o_tx_data); end
        checks++; if ({o_alu_OP, o_alu_A, o_alu_B} !== 22'h0) begin errors++; $display("FAIL rst_alu: got %02h/%02h/%02h, expected 0", o_alu_OP, o_alu_A, o_alu_B); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", o_busy); end
        checks++; if (o_err_count !== 8'h00) begin errors++; $display("FAIL rst_err: got %02h, expected 00", o_err_count); end
        i_reset = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_valid_frame;
        bit ok;
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        send_byte(8'hAA); send_byte(8'h20); send_byte(8'h05); send_byte(8'h03); send_byte(8'h26);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL valid_idle: busy=%b after budget, expected 0", o_busy); end
        checks++; if ({o_alu_OP, o_alu_A, o_alu_B} !== {6'h20, 8'h05, 8'h03}) begin errors++; $display("FAIL valid_alu: got %02h/%02h/%02h, expected 20/05/03", o_alu_OP, o_alu_A, o_alu_B); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL valid_missing_tx: %0d bytes outstanding, expected 0", exp_q.size()); end
        checks++; if (o_err_count !== exp_err) begin errors++; $display("FAIL valid_err: got %02h, expected %02h", o_err_count, exp_err); end
    endtask

    task automatic test_ops;
        bit ok;
        logic [7:0] ops [4] = '{8'h22, 8'h20, 8'h22, 8'h20};
        logic [7:0] as  [4] = '{8'h10, 8'h7F, 8'h05, 8'hAA};
        logic [7:0] bs  [4] = '{8'h03, 8'h01, 8'h05, 8'h01};
        for (int i = 0; i < 4; i++) begin
            push_resp(ops[i], as[i], bs[i]);
            send_frame(ops[i], as[i], bs[i]);
            wait_idle(200, ok);
            checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL ops_%0d: idle=%b outstanding=%0d, expected 1/0", i, ok, exp_q.size()); end
        end
        // last frame left SUB 05-05 on the ALU; then ADD AA+01 (SOF byte as data)
        checks++; if ({o_alu_OP, o_alu_A, o_alu_B} !== {6'h20, 8'hAA, 8'h01}) begin errors++; $display("FAIL ops_alu: got %02h/%02h/%02h, expected 20/AA/01", o_alu_OP, o_alu_A, o_alu_B); end
    endtask

    task automatic test_bad_chk;
        bit ok;
        exp_q.push_back(8'h15);
        exp_err = exp_err + 8'd1;
        send_byte(8'hAA); send_byte(8'h20); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL badchk_done: idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size()); end
        checks++; if ({o_alu_OP, o_alu_A, o_alu_B} !== {6'h20, 8'hAA, 8'h01}) begin errors++; $display("FAIL badchk_alu: got %02h/%02h/%02h, expected unchanged 20/AA/01", o_alu_OP, o_alu_A, o_alu_B); end
        checks++; if (o_err_count !== exp_err) begin errors++; $display("FAIL badchk_err: got %02h, expected %02h", o_err_count, exp_err); end
    endtask

    task automatic test_bad_op;
        bit ok;
        exp_q.push_back(8'h15);
        exp_err = exp_err + 8'd1;
        send_byte(8'hAA); send_byte(8'hE0); send_byte(8'h05); send_byte(8'h03); send_byte(8'hE6);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL badop_done: idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size()); end
        checks++; if (o_err_count !== exp_err) begin errors++; $display("FAIL badop_err: got %02h, expected %02h", o_err_count, exp_err); end
    endtask

    task automatic test_timeout;
        bit ok;
        send_byte(8'hAA);
        send_byte(8'h20);
        i_tick = 1'b1;
        repeat (3199) @(negedge i_clk);
        i_tick = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL tmo_early: busy=%b after 3199 ticks, expected 1", o_busy); end
        i_tick = 1'b1;
        @(negedge i_clk);
        i_tick = 1'b0;
        exp_err = exp_err + 8'd1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL tmo_expire: busy=%b after 3200 ticks, expected 0", o_busy); end
        checks++; if (o_err_count !== exp_err) begin errors++; $display("FAIL tmo_err: got %02h, expected %02h", o_err_count, exp_err); end
        push_resp(8'h24, 8'h0F, 8'h3C);
        send_frame(8'h24, 8'h0F, 8'h3C);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL tmo_next_frame: idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size()); end
    endtask

    task automatic test_timeout_race;
        bit ok;
        push_resp(8'h25, 8'h0F, 8'hF0);
        send_byte(8'hAA);
        i_tick = 1'b1;
        repeat (3199) @(negedge i_clk);
        i_rx_data = 8'h25;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_tick = 1'b0;
        i_rx_done = 1'b0;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL race_busy: busy=%b, expected byte to win over timeout", o_busy); end
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'h25 ^ 8'h0F ^ 8'hF0);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL race_frame: idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size()); end
        checks++; if (o_err_count !== exp_err) begin errors++; $display("FAIL race_err: got %02h, expected %02h", o_err_count, exp_err); end
    endtask

    task automatic test_ignore;
        bit ok;
        send_byte(8'h55);
        send_byte(8'h13);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ign_idle: busy=%b after junk, expected 0", o_busy); end
        push_resp(8'h22, 8'h40, 8'h01);
        send_frame(8'h22, 8'h40, 8'h01);
        wait_start(50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_start: no tx start, expected one"); end
        @(negedge i_clk);
        send_byte(8'hAA);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL ign_resp: idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size()); end
    endtask

    task automatic test_reset_wait_res;
        bit ok;
        logic [9:0] r;
        r = alu_fn(6'h20, 8'h11, 8'h22);
        exp_q.push_back(r[7:0]);
        send_frame(8'h20, 8'h11, 8'h22);
        wait_start(50, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rwr_start: no tx start, expected one"); end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        exp_err = 8'h00;
        checks++; if ({o_tx_start, o_busy, o_tx_data} !== 10'h000) begin errors++; $display("FAIL rwr_outputs: start=%b busy=%b data=%02h, expected 0/0/00", o_tx_start, o_busy, o_tx_data); end
        checks++; if ({o_alu_OP, o_alu_A, o_alu_B, o_err_count} !== 30'h0) begin errors++; $display("FAIL rwr_alu_err: %02h/%02h/%02h err=%02h, expected all 0", o_alu_OP, o_alu_A, o_alu_B, o_err_count); end
        i_reset = 1'b1;
        repeat (15) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL rwr_after: busy=%b outstanding=%0d, expected 0/0", o_busy, exp_q.size()); end
        push_resp(8'h20, 8'h30, 8'h04);
        send_frame(8'h20, 8'h30, 8'h04);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL rwr_recover: idle=%b outstanding=%0d, expected 1/0", ok, exp_q.size()); end
    endtask

    task automatic test_err_saturate;
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            exp_q.push_back(8'h15);
            send_byte(8'hAA); send_byte(8'hE0); send_byte(8'h05); send_byte(8'h03); send_byte(8'hE6);
            wait_idle(200, ok);
            all_ok = all_ok & ok;
            if (n == 254) begin
                checks++; if (o_err_count !== 8'hFE) begin errors++; $display("FAIL sat_254: got %02h, expected FE", o_err_count); end
            end
        end
        checks++; if (all_ok !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL sat_naks: all_idle=%b outstanding=%0d, expected 1/0", all_ok, exp_q.size()); end
        checks++; if (o_err_count !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %02h, expected FF", o_err_count); end
    endtask

    initial begin
        i_reset   = 1'b0;
        i_tick    = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        exp_err   = 8'h00;
        @(negedge i_clk);
        test_reset();
        test_valid_frame();
        test_ops();
        test_bad_chk();
        test_bad_op();
        test_timeout();
        test_timeout_race();
        test_ignore();
        test_reset_wait_res();
        test_err_saturate();
        repeat (5) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
